// File: rtl/sequential_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, LO = quotient, HI = remainder.
// Latency: done rises WIDTH+1 edges after the start edge, or 1 edge after it for a zero divisor.
// Optional DIV_EARLY_OUT_EN: finish in 1 edge when |dividend| < |divisor|; results match the default build.
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, quo, dvs, dvd_raw;
  logic             sign_q, sign_r, dbz;
  logic [CW-1:0]    cnt;
  logic             done_r;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which is exact unsigned.
  logic             neg_a, neg_b, divisor_zero, early;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign neg_a        = is_signed & dividend[WIDTH-1];
  assign neg_b        = is_signed & divisor[WIDTH-1];
  assign mag_a        = neg_a ? (~dividend + 1'b1) : dividend;
  assign mag_b        = neg_b ? (~divisor + 1'b1) : divisor;
  assign divisor_zero = (divisor == '0);
`ifdef DIV_EARLY_OUT_EN
  assign early        = !divisor_zero && (mag_a < mag_b);
`else
  assign early        = 1'b0;
`endif

  // Trial subtract is one bit wider than the shifted remainder so a borrow shows up in the top bit.
  logic [WIDTH:0]   rem_sh, trial;
  logic             borrow;

  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs};
  assign borrow = trial[WIDTH];

  // Sign-corrected results, applied on the FIXUP edge.
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign quo_fix = sign_q ? (~quo + 1'b1) : quo;
  assign rem_fix = sign_r ? (~rem + 1'b1) : rem;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: zero divisor and early-out cases skip the iteration phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor_zero || early) ? FIXUP : RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: busy covers every non-idle cycle; done is the registered FIXUP pulse.
  always_comb begin
    busy = (state != IDLE);
    done = done_r;
  end

  // Datapath: latch operands on start, then one restoring shift-subtract step per RUN edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      dbz     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem     <= early ? mag_a : '0;
            quo     <= early ? '0 : mag_a;
            dvs     <= mag_b;
            dvd_raw <= dividend;
            sign_q  <= neg_a ^ neg_b;
            sign_r  <= neg_a;
            dbz     <= divisor_zero;
            cnt     <= CW'(WIDTH);
          end
        end
        RUN: begin
          quo <= {quo[WIDTH-2:0], ~borrow};
          rem <= borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers: written only on the FIXUP edge and held until the next one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done_r <= (state == FIXUP);
      if (state == FIXUP) begin
        quotient    <= dbz ? '1 : quo_fix;
        remainder   <= dbz ? dvd_raw : rem_fix;
        div_by_zero <= dbz;
      end
    end
  end

endmodule
